// File: rtl/sram_device_model_if.sv
// Controller-side address and strobe bundle for the asynchronous SRAM device model.
// The bidirectional data bus stays a plain inout port on the device.
interface sram_device_model_if #(
   parameter int ADDR_W = 17
);
   logic [ADDR_W-1:0] Sram_addr;
   logic              Sram_cen;
   logic              Sram_oen;
   logic              Sram_wen;

   modport master (output Sram_addr, Sram_cen, Sram_oen, Sram_wen);
   modport slave  (input  Sram_addr, Sram_cen, Sram_oen, Sram_wen);
endinterface

// File: rtl/sram_device_model.sv
// Byte-wide asynchronous SRAM model with 4-byte burst monitor, protocol error flags
// and saturating access counters.
module sram_device_model #(
   parameter int ADDR_W     = 17,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic              clk,
   input  logic              rst,
   sram_device_model_if.slave bus,
   inout  wire  [7:0]        Sram_iodata,
   output logic              mon_wvalid,
   output logic [ADDR_W-1:0] mon_waddr,
   output logic [31:0]       mon_wdata,
   output logic              mon_rvalid,
   output logic [ADDR_W-1:0] mon_raddr,
   output logic [31:0]       mon_rdata,
   output logic              err_contention,
   output logic              err_range,
   output logic              err_seq,
   output logic [15:0]       wr_count,
   output logic [15:0]       rd_count
);
   typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

   logic [7:0] mem [0:(2**DEPTH_LOG2)-1];

   logic is_rd, is_wr, is_bad, is_nop, in_range;
   logic [DEPTH_LOG2-1:0] mem_idx;
   logic [7:0] rd_byte, byte_in;

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       word_q, word_d;
   logic              wdone, rdone, seq_set;

   logic              mon_wvalid_q, mon_rvalid_q;
   logic [ADDR_W-1:0] mon_waddr_q, mon_raddr_q;
   logic [31:0]       mon_wdata_q, mon_rdata_q;
   logic              err_cont_q, err_range_q, err_seq_q;
   logic [15:0]       wr_count_q, rd_count_q;

   assign is_bad   = !bus.Sram_cen && !bus.Sram_wen && !bus.Sram_oen;
   assign is_wr    = !bus.Sram_cen && !bus.Sram_wen &&  bus.Sram_oen;
   assign is_rd    = !bus.Sram_cen &&  bus.Sram_wen && !bus.Sram_oen;
   assign is_nop   = !(is_bad || is_wr || is_rd);
   assign in_range = (bus.Sram_addr >> DEPTH_LOG2) == '0;
   assign mem_idx  = bus.Sram_addr[DEPTH_LOG2-1:0];

   assign rd_byte     = in_range ? mem[mem_idx] : 8'h00;
   assign Sram_iodata = is_rd ? rd_byte : 8'bz;
   assign byte_in     = is_wr ? Sram_iodata : rd_byte;

   // Memory is left out of reset so contents survive it; reset only blocks the write.
   always_ff @(posedge clk) begin
      if (!rst && is_wr && in_range) begin
         mem[mem_idx] <= Sram_iodata;
      end
   end

   always_comb begin
      logic start;
      logic cont;
      state_d = state_q;
      idx_d   = idx_q;
      base_d  = base_q;
      word_d  = word_q;
      wdone   = 1'b0;
      rdone   = 1'b0;
      seq_set = 1'b0;
      start   = 1'b0;
      cont    = ((state_q == WBURST && is_wr) || (state_q == RBURST && is_rd)) &&
                (bus.Sram_addr == base_q + ADDR_W'(idx_q));
      if (is_bad) begin
         state_d = IDLE;
         idx_d   = 2'd0;
      end else if (state_q == IDLE) begin
         start = is_wr || is_rd;
      end else if (cont) begin
         word_d[{idx_q, 3'b000} +: 8] = byte_in;
         idx_d = idx_q + 2'd1;
         if (idx_q == 2'd3) begin
            state_d = IDLE;
            wdone   = (state_q == WBURST);
            rdone   = (state_q == RBURST);
         end
      end else if (is_nop) begin
         seq_set = 1'b1;
         state_d = IDLE;
         idx_d   = 2'd0;
      end else begin
         seq_set = 1'b1;
         start   = 1'b1;
      end
      if (start) begin
         word_d  = {24'h0, byte_in};
         base_d  = bus.Sram_addr;
         idx_d   = 2'd1;
         state_d = is_wr ? WBURST : RBURST;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= 2'd0;
         base_q       <= '0;
         word_q       <= '0;
         mon_wvalid_q <= 1'b0;
         mon_rvalid_q <= 1'b0;
         mon_waddr_q  <= '0;
         mon_raddr_q  <= '0;
         mon_wdata_q  <= '0;
         mon_rdata_q  <= '0;
         err_cont_q   <= 1'b0;
         err_range_q  <= 1'b0;
         err_seq_q    <= 1'b0;
         wr_count_q   <= '0;
         rd_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         base_q       <= base_d;
         word_q       <= word_d;
         mon_wvalid_q <= wdone;
         mon_rvalid_q <= rdone;
         if (wdone) begin
            mon_waddr_q <= base_q;
            mon_wdata_q <= word_d;
         end
         if (rdone) begin
            mon_raddr_q <= base_q;
            mon_rdata_q <= word_d;
         end
         if (is_bad)                         err_cont_q  <= 1'b1;
         if ((is_wr || is_rd) && !in_range)  err_range_q <= 1'b1;
         if (seq_set)                        err_seq_q   <= 1'b1;
         if (is_wr && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
         if (is_rd && rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
      end
   end

   assign mon_wvalid     = mon_wvalid_q;
   assign mon_waddr      = mon_waddr_q;
   assign mon_wdata      = mon_wdata_q;
   assign mon_rvalid     = mon_rvalid_q;
   assign mon_raddr      = mon_raddr_q;
   assign mon_rdata      = mon_rdata_q;
   assign err_contention = err_cont_q;
   assign err_range      = err_range_q;
   assign err_seq        = err_seq_q;
   assign wr_count       = wr_count_q;
   assign rd_count       = rd_count_q;
endmodule

// File: tb/tb_sram_device_model.sv
// Bench for sram_device_model: directed scenarios plus randomized traffic compared every
// cycle against a queue-based burst model.
module tb_sram_device_model;
   localparam int ADDR_W     = 17;
   localparam int DEPTH_LOG2 = 12;
   localparam int DEPTH      = 1 << DEPTH_LOG2;
   localparam int C_NOP = 0, C_RD = 1, C_WR = 2, C_BAD = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_device_model_if #(.ADDR_W(ADDR_W)) bus_if ();
   wire  [7:0] Sram_iodata;
   logic [7:0] tb_dout  = 8'h00;
   logic       tb_drive = 1'b0;
   assign Sram_iodata = tb_drive ? tb_dout : 8'bz;

   logic              mon_wvalid, mon_rvalid;
   logic [ADDR_W-1:0] mon_waddr, mon_raddr;
   logic [31:0]       mon_wdata, mon_rdata;
   logic              err_contention, err_range, err_seq;
   logic [15:0]       wr_count, rd_count;

   sram_device_model #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk(clk), .rst(rst), .bus(bus_if.slave), .Sram_iodata(Sram_iodata),
      .mon_wvalid(mon_wvalid), .mon_waddr(mon_waddr), .mon_wdata(mon_wdata),
      .mon_rvalid(mon_rvalid), .mon_raddr(mon_raddr), .mon_rdata(mon_rdata),
      .err_contention(err_contention), .err_range(err_range), .err_seq(err_seq),
      .wr_count(wr_count), .rd_count(rd_count)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]        m_mem [DEPTH];
   logic [7:0]        b_q [$];
   logic [ADDR_W-1:0] b_base;
   int                b_dir;
   bit                model_ok = 0;
   logic              e_wvalid, e_rvalid, e_cont, e_range, e_seq;
   logic [ADDR_W-1:0] e_waddr, e_raddr;
   logic [31:0]       e_wdata, e_rdata;
   logic [15:0]       e_wcnt, e_rcnt;

   function automatic int cls_of(input logic cen, input logic oen, input logic wen);
      if (cen)              return C_NOP;
      if (!wen && !oen)     return C_BAD;
      if (!wen)             return C_WR;
      if (!oen)             return C_RD;
      return C_NOP;
   endfunction

   function automatic logic [7:0] read_exp(input logic [ADDR_W-1:0] a);
      if (a < DEPTH) return m_mem[a[DEPTH_LOG2-1:0]];
      return 8'h00;
   endfunction

   task automatic model_step();
      int c;
      logic [ADDR_W-1:0] a;
      logic [7:0] b;
      logic [31:0] word;
      c = cls_of(bus_if.Sram_cen, bus_if.Sram_oen, bus_if.Sram_wen);
      a = bus_if.Sram_addr;
      model_ok = 1;
      e_wvalid = 0;
      e_rvalid = 0;
      if (rst) begin
         {e_cont, e_range, e_seq} = '0;
         e_waddr = '0; e_raddr = '0; e_wdata = '0; e_rdata = '0;
         e_wcnt = '0; e_rcnt = '0;
         b_q.delete();
         return;
      end
      if ((c == C_WR || c == C_RD) && a >= DEPTH) e_range = 1;
      if (c == C_WR && e_wcnt != 16'hFFFF) e_wcnt++;
      if (c == C_RD && e_rcnt != 16'hFFFF) e_rcnt++;
      if (c == C_BAD) begin
         e_cont = 1;
         b_q.delete();
      end else if (c == C_NOP) begin
         if (b_q.size() != 0) e_seq = 1;
         b_q.delete();
      end else begin
         b = (c == C_WR) ? tb_dout : read_exp(a);
         if (b_q.size() != 0 && c == b_dir && a == ADDR_W'(b_base + b_q.size())) begin
            b_q.push_back(b);
         end else begin
            if (b_q.size() != 0) e_seq = 1;
            b_q.delete();
            b_q.push_back(b);
            b_base = a;
            b_dir  = c;
         end
         if (c == C_WR && a < DEPTH) m_mem[a[DEPTH_LOG2-1:0]] = b;
         if (b_q.size() == 4) begin
            word = {b_q[3], b_q[2], b_q[1], b_q[0]};
            if (c == C_WR) begin
               e_wvalid = 1; e_waddr = b_base; e_wdata = word;
            end else begin
               e_rvalid = 1; e_raddr = b_base; e_rdata = word;
            end
            b_q.delete();
         end
      end
   endtask

   // One bus cycle: the model absorbs the cycle just sampled, then the next one is driven.
   task automatic cyc(input bit r, input int c, input logic [ADDR_W-1:0] a, input logic [7:0] d);
      @(posedge clk);
      model_step();
      #2;
      rst = r;
      bus_if.Sram_addr = a;
      tb_dout = d;
      tb_drive = (c != C_RD);
      case (c)
         C_RD:    {bus_if.Sram_cen, bus_if.Sram_oen, bus_if.Sram_wen} = 3'b001;
         C_WR:    {bus_if.Sram_cen, bus_if.Sram_oen, bus_if.Sram_wen} = 3'b010;
         C_BAD:   {bus_if.Sram_cen, bus_if.Sram_oen, bus_if.Sram_wen} = 3'b000;
         default: {bus_if.Sram_cen, bus_if.Sram_oen, bus_if.Sram_wen} =
                     ($urandom_range(0, 1) == 0) ? 3'b111 : 3'b011;
      endcase
      #1;
   endtask

   // ---------------- compare process ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            chk("wvalid", mon_wvalid, e_wvalid);
            chk("waddr", mon_waddr, e_waddr);
            chk("wdata", mon_wdata, e_wdata);
            chk("rvalid", mon_rvalid, e_rvalid);
            chk("raddr", mon_raddr, e_raddr);
            chk("rdata", mon_rdata, e_rdata);
            chk("err_contention", err_contention, e_cont);
            chk("err_range", err_range, e_range);
            chk("err_seq", err_seq, e_seq);
            chk("wr_count", wr_count, e_wcnt);
            chk("rd_count", rd_count, e_rcnt);
            if (cls_of(bus_if.Sram_cen, bus_if.Sram_oen, bus_if.Sram_wen) == C_RD)
               chk("rd_bus", Sram_iodata, read_exp(bus_if.Sram_addr));
            else
               chk("bus_released", Sram_iodata, tb_dout);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int pc;
      logic [ADDR_W-1:0] pa;
      bus_if.Sram_addr = '0;
      {bus_if.Sram_cen, bus_if.Sram_oen, bus_if.Sram_wen} = 3'b111;

      cyc(1, C_NOP, 0, 0);
      cyc(0, C_NOP, 0, 0);
      chk("lit_reset_wcnt", wr_count, 0);
      chk("lit_reset_flags", {err_contention, err_range, err_seq}, 0);

      // four-byte write burst
      cyc(0, C_WR, 17'h010, 8'h11);
      cyc(0, C_WR, 17'h011, 8'h22);
      cyc(0, C_WR, 17'h012, 8'h33);
      cyc(0, C_WR, 17'h013, 8'h44);
      cyc(0, C_NOP, 0, 8'h00);
      chk("lit_wvalid", mon_wvalid, 1);
      chk("lit_waddr", mon_waddr, 32'h010);
      chk("lit_wdata", mon_wdata, 32'h44332211);
      chk("lit_wcnt4", wr_count, 4);
      cyc(0, C_NOP, 0, 8'h00);
      chk("lit_wvalid_pulse", mon_wvalid, 0);
      chk("lit_wdata_hold", mon_wdata, 32'h44332211);

      // read it back
      cyc(0, C_RD, 17'h010, 0); chk("lit_rd0", Sram_iodata, 8'h11);
      cyc(0, C_RD, 17'h011, 0); chk("lit_rd1", Sram_iodata, 8'h22);
      cyc(0, C_RD, 17'h012, 0); chk("lit_rd2", Sram_iodata, 8'h33);
      cyc(0, C_RD, 17'h013, 0); chk("lit_rd3", Sram_iodata, 8'h44);
      cyc(0, C_NOP, 0, 0);
      chk("lit_rvalid", mon_rvalid, 1);
      chk("lit_raddr", mon_raddr, 32'h010);
      chk("lit_rdata", mon_rdata, 32'h44332211);

      // broken burst: NOP after two bytes
      cyc(0, C_WR, 17'h020, 8'hAA);
      cyc(0, C_WR, 17'h021, 8'hBB);
      cyc(0, C_NOP, 0, 0);
      cyc(0, C_NOP, 0, 0);
      chk("lit_err_seq", err_seq, 1);
      chk("lit_no_wvalid", mon_wvalid, 0);
      cyc(0, C_RD, 17'h020, 0); chk("lit_partial_kept", Sram_iodata, 8'hAA);

      // contention cycle
      cyc(0, C_BAD, 17'h010, 8'h99);
      cyc(0, C_NOP, 0, 0);
      chk("lit_err_cont", err_contention, 1);
      cyc(0, C_RD, 17'h010, 0); chk("lit_bad_nowrite", Sram_iodata, 8'h11);

      // out-of-range read
      cyc(0, C_RD, 17'h1F000, 0); chk("lit_oor_data", Sram_iodata, 8'h00);
      cyc(0, C_NOP, 0, 0);
      chk("lit_err_range", err_range, 1);
      chk("lit_rcnt", rd_count, 7);

      // reset in the middle of a write burst, with a coincident write
      cyc(0, C_WR, 17'h032, 8'hC3);
      cyc(0, C_NOP, 0, 0);
      cyc(0, C_WR, 17'h030, 8'h5A);
      cyc(0, C_WR, 17'h031, 8'hA5);
      cyc(1, C_WR, 17'h032, 8'h77);
      cyc(0, C_NOP, 0, 0);
      chk("lit_rst_flags", {err_contention, err_range, err_seq}, 0);
      chk("lit_rst_counts", {wr_count, rd_count}, 0);
      chk("lit_rst_mon", {31'h0, mon_wvalid} | mon_wdata | 32'(mon_waddr) | mon_rdata, 0);
      cyc(0, C_NOP, 0, 0);
      chk("lit_rst_novalid", mon_wvalid, 0);
      cyc(0, C_RD, 17'h030, 0); chk("lit_persist0", Sram_iodata, 8'h5A);
      cyc(0, C_RD, 17'h031, 0); chk("lit_persist1", Sram_iodata, 8'hA5);
      cyc(0, C_RD, 17'h032, 0); chk("lit_rst_blocks_wr", Sram_iodata, 8'hC3);

      // burst wrapping the top of the address space
      cyc(0, C_WR, 17'h1FFFE, 8'h01);
      cyc(0, C_WR, 17'h1FFFF, 8'h02);
      cyc(0, C_WR, 17'h00000, 8'h03);
      cyc(0, C_WR, 17'h00001, 8'h04);
      cyc(0, C_NOP, 0, 0);
      chk("lit_wrap_valid", mon_wvalid, 1);
      chk("lit_wrap_addr", mon_waddr, 32'h1FFFE);
      chk("lit_wrap_data", mon_wdata, 32'h04030201);

      // fill the whole array so every later read has a known value
      for (int i = 0; i < DEPTH; i++) cyc(0, C_WR, ADDR_W'(i), 8'($urandom));
      cyc(0, C_NOP, 0, 0);

      // randomized traffic
      pc = C_NOP;
      pa = '0;
      for (int i = 0; i < 4000; i++) begin
         int r;
         int c;
         logic [ADDR_W-1:0] a;
         r = $urandom_range(0, 99);
         if (r == 0) begin
            cyc(1, C_NOP, 0, 0);
            pc = C_NOP;
            continue;
         end
         if (r < 70 && (pc == C_WR || pc == C_RD)) begin
            c = pc;
            a = pa + 1'b1;
         end else begin
            r = $urandom_range(0, 99);
            c = (r < 15) ? C_NOP : (r < 55) ? C_RD : (r < 95) ? C_WR : C_BAD;
            r = $urandom_range(0, 99);
            a = (r < 85) ? ADDR_W'($urandom_range(0, DEPTH - 1)) :
                (r < 95) ? ADDR_W'($urandom_range(32'h1FFFC, 32'h1FFFF)) :
                           ADDR_W'($urandom);
         end
         cyc(0, c, a, 8'($urandom));
         pc = c;
         pa = a;
      end
      cyc(0, C_NOP, 0, 0);
      cyc(0, C_NOP, 0, 0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sram_device_model.md
SRAM_DEVICE_MODEL -- requirements
Module: sram_device_model

Interface
REQ-001 Parameter ADDR_W, default 17, SRAM address width.
REQ-002 Parameter DEPTH_LOG2, default 12, log2 of implemented byte locations (4096); DEPTH_LOG2 <= ADDR_W.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 Sram_addr  in  ADDR_W  byte address from controller.
REQ-006 Sram_iodata  inout  8  bidirectional data bus.
REQ-007 Sram_cen / Sram_oen / Sram_wen  in  1 each  chip / output / write enable, active-low.
REQ-008 mon_wvalid  out  1  one-cycle pulse: 4-byte write burst completed.
REQ-009 mon_waddr  out  ADDR_W  base address of the completed write burst.
REQ-010 mon_wdata  out  32  assembled write word.
REQ-011 mon_rvalid / mon_raddr / mon_rdata  out  1 / ADDR_W / 32  same as above for read bursts.
REQ-012 err_contention / err_range / err_seq  out  1 each  sticky protocol error flags.
REQ-013 wr_count / rd_count  out  16 each  accepted write / read byte cycles, saturating.

Function
REQ-014 Each cycle is classified combinationally: NOP (cen=1, or cen=0 with wen=1 and oen=1), RD (cen=0, oen=0, wen=1), WR (cen=0, wen=0, oen=1), BAD (cen=0, wen=0, oen=0).
REQ-015 In-range means Sram_addr < 2**DEPTH_LOG2; the array is indexed by Sram_addr[DEPTH_LOG2-1:0].
REQ-016 Read is asynchronous: in RD, Sram_iodata = mem[addr] combinationally if in range, 8'h00 if out of range; Sram_iodata = 8'bz in every other class.
REQ-017 Write is synchronous: at the rising edge in WR with in-range address, mem[addr] <= Sram_iodata; out-of-range WR writes nothing.
REQ-018 RD or WR with an out-of-range address sets err_range at that edge.
REQ-019 BAD sets err_contention, writes nothing, drives nothing, and returns the burst FSM to IDLE without setting err_seq.
REQ-020 Burst FSM states: IDLE, WBURST, RBURST; byte index idx is 2 bits; base is an ADDR_W register.
REQ-021 IDLE: WR -> capture byte 0, base <= addr, idx <= 1, go WBURST; RD -> same into RBURST, capturing the driven byte; NOP -> stay.
REQ-022 WBURST/RBURST, same-direction cycle with addr == base + idx -> capture byte at lane idx, idx <= idx + 1; if idx was 3, go IDLE and pulse the matching mon_*valid on the following cycle.
REQ-023 Mid-burst NOP -> err_seq set, go IDLE, no valid pulse.
REQ-024 Mid-burst address mismatch or direction change -> err_seq set, discard partial word, treat the cycle as IDLE byte 0 of a new burst.
REQ-025 Word packing is little-endian: byte at base+k occupies bits [8k+7:8k].
REQ-026 mon_wvalid/mon_rvalid are registered, high exactly one cycle; mon_*addr/mon_*data hold until the next completion.
REQ-027 Address arithmetic base + idx is ADDR_W wide and wraps modulo 2**ADDR_W.
REQ-028 wr_count increments on each WR cycle and rd_count on each RD cycle, in or out of range; both saturate at 16'hFFFF.
REQ-029 Error flags are sticky until reset; multiple flags may be set in the same cycle.
REQ-030 A burst-completing cycle that also sets err_range still completes the burst and pulses valid.

Reset
REQ-031 While rst=1 at a rising edge: FSM <= IDLE, idx <= 0, all mon_* outputs <= 0, error flags <= 0, counters <= 0.
REQ-032 Memory contents are not affected by reset.
REQ-033 Reset mid-burst discards the partial word; no valid pulse follows.
REQ-034 Reset has priority over a coincident WR, so no memory write occurs in that cycle.

Verification
REQ-035 WR bytes 11,22,33,44 to addresses 0x010..0x013 on consecutive cycles -> next cycle mon_wvalid=1, mon_waddr=0x010, mon_wdata=0x44332211, wr_count=4.
REQ-036 After REQ-035, RD at 0x010..0x013 -> Sram_iodata 0x11,0x22,0x33,0x44 in the same cycle, then mon_rvalid=1, mon_rdata=0x44332211.
REQ-037 WR at 0x020, 0x021, then a NOP -> err_seq=1, no mon_wvalid, mem[0x020]=byte0.
REQ-038 cen=0, wen=0, oen=0 for one cycle -> err_contention=1, Sram_iodata=z, memory unchanged.
REQ-039 RD at address 0x1F000 with DEPTH_LOG2=12 -> Sram_iodata=0x00, err_range=1, rd_count increments.
REQ-040 Assert rst after byte 2 of a write burst -> flags, counters, and mon_* outputs read 0; no valid pulse; written bytes persist in memory.
